// File: rtl/modinv_fermat_2969.sv
// Modular inverse in GF(Q) by Fermat: a^(Q-2) mod Q, computed with one
// square-or-multiply per cycle and Barrett reduction, behind valid/ready handshakes.
module modinv_fermat_2969 #(
   parameter int Q = 2969,
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] inv,
   output logic         err
);

   localparam int K  = 2 * W;
   localparam int IW = $clog2(W);
   localparam logic [W-1:0]  E_VEC     = W'(Q - 2);
   localparam int            E_MSB     = $clog2(Q - 1) - 1;
   localparam logic [IW-1:0] IDX_START = IW'(E_MSB - 1);
   localparam logic [W-1:0]  Q_W       = W'(Q);
   localparam logic [K-1:0]  Q_K       = K'(Q);
   localparam logic [W+1:0]  BM        = (W+2)'((64'(1) << K) / Q);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic {SQ, MUL} phase_t;

   state_t        state, state_n;
   phase_t        phase, phase_n;
   logic [IW-1:0] idx, idx_n;
   logic [W-1:0]  acc, acc_n;
   logic [W-1:0]  a_reg, a_reg_n;
   logic          err_r, err_n;
   logic [W-1:0]  mult_b;
   logic [K-1:0]  prod;
   logic [W-1:0]  red;

   // Quotient estimate undershoots by at most one, so one conditional subtract lands in [0, Q-1].
   function automatic logic [W-1:0] barrett(input logic [K-1:0] x);
      logic [3*W+1:0] t;
      logic [K-1:0]   q;
      logic [K-1:0]   r;
      t = {{(W+2){1'b0}}, x} * {{K{1'b0}}, BM};
      q = K'(t >> K);
      r = x - q * Q_K;
      if (r >= Q_K) r = r - Q_K;
      return W'(r);
   endfunction

   assign mult_b = (phase == SQ) ? acc : a_reg;
   assign prod   = {{W{1'b0}}, acc} * {{W{1'b0}}, mult_b};
   assign red    = barrett(prod);

   always_comb begin
      state_n = state;
      phase_n = phase;
      idx_n   = idx;
      acc_n   = acc;
      a_reg_n = a_reg;
      err_n   = err_r;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_reg_n = a;
               if (a != '0 && a < Q_W) begin
                  acc_n   = a;
                  idx_n   = IDX_START;
                  phase_n = SQ;
                  err_n   = 1'b0;
                  state_n = RUN;
               end else begin
                  acc_n   = '0;
                  err_n   = 1'b1;
                  state_n = DONE;
               end
            end
         end
         RUN: begin
            acc_n = red;
            // A set exponent bit means the square is followed by a multiply at the same index.
            if (phase == SQ && E_VEC[idx]) begin
               phase_n = MUL;
            end else begin
               phase_n = SQ;
               if (idx == '0) state_n = DONE;
               else           idx_n   = idx - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         phase <= SQ;
         idx   <= '0;
         acc   <= '0;
         a_reg <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         idx   <= idx_n;
         acc   <= acc_n;
         a_reg <= a_reg_n;
         err_r <= err_n;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign inv       = acc;
   assign err       = err_r;

endmodule

// File: tb/tb_modinv_fermat_2969.sv
// Directed bench for modinv_fermat_2969: known inverses, full sweep, errors,
// backpressure, asynchronous reset and back-to-back issue.
module tb_modinv_fermat_2969;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] inv;
   logic        err;

   int errors = 0;
   int checks = 0;

   modinv_fermat_2969 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inv       (inv),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operand with out_ready high; lat counts edges from acceptance to out_valid.
   task automatic run_op(input logic [11:0] av, output logic [11:0] rv, output logic re,
                         output int lat);
      int n;
      a = av;
      in_valid = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      rv = inv;
      re = err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      out_ready = 1'b1;
      #12;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      checks++;
      if (inv !== 12'd0) begin errors++; $display("FAIL reset_inv got=%0d want=0", inv); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_one();
      logic [11:0] rv;
      logic re;
      int lat;
      run_op(12'd1, rv, re, lat);
      checks++;
      if (rv !== 12'd1) begin errors++; $display("FAIL one_inv got=%0d want=1", rv); end
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL one_err got=%0b want=0", re); end
      checks++;
      if (lat !== 18) begin errors++; $display("FAIL one_latency got=%0d want=18", lat); end
   endtask

   task automatic test_known();
      logic [11:0] ins [4]  = '{12'd2, 12'd3, 12'd23, 12'd2968};
      logic [11:0] outs [4] = '{12'd1485, 12'd990, 12'd1420, 12'd2968};
      logic [11:0] rv;
      logic re;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ins[i], rv, re, lat);
         checks++;
         if (rv !== outs[i] || re !== 1'b0 || lat !== 18)
            begin errors++; $display("FAIL known a=%0d got inv=%0d err=%0b lat=%0d want inv=%0d err=0 lat=18",
                                      ins[i], rv, re, lat, outs[i]); end
      end
   endtask

   task automatic test_sweep();
      logic [11:0] rv;
      logic re;
      int lat;
      for (int v = 1; v < 2969; v++) begin
         run_op(12'(v), rv, re, lat);
         checks++;
         if (re !== 1'b0 || ((v * int'(rv)) % 2969) != 1)
            begin errors++; $display("FAIL sweep a=%0d got inv=%0d err=%0b want a*inv%%2969=1 err=0", v, rv, re); end
      end
   endtask

   task automatic test_invalid();
      logic [11:0] ins [3] = '{12'd0, 12'd2969, 12'd4095};
      logic [11:0] rv;
      logic re;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(ins[i], rv, re, lat);
         checks++;
         if (rv !== 12'd0 || re !== 1'b1 || lat !== 0)
            begin errors++; $display("FAIL invalid a=%0d got inv=%0d err=%0b lat=%0d want inv=0 err=1 lat=0",
                                      ins[i], rv, re, lat); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      a = 12'd2;
      in_valid = 1'b1;
      out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      n = 0;
      while (!out_valid && n < 100) begin
         a = 12'($urandom_range(4095, 0));
         in_valid = n[0];
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      checks++;
      if (n !== 18) begin errors++; $display("FAIL bp_latency got=%0d want=18", n); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (inv !== 12'd1485 || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL bp_hold cyc=%0d got inv=%0d ov=%0b ir=%0b err=%0b want 1485 1 0 0",
                                      i, inv, out_valid, in_ready, err); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL bp_release got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid();
      logic [11:0] rv;
      logic re;
      int lat;
      int n;
      a = 12'd3;
      in_valid = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || inv !== 12'd0 || in_ready !== 1'b1 || err !== 1'b0)
         begin errors++; $display("FAIL reset_mid got ov=%0b inv=%0d ir=%0b err=%0b want 0 0 1 0",
                                   out_valid, inv, in_ready, err); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || inv !== 12'd0)
         begin errors++; $display("FAIL reset_mid_hold got ov=%0b inv=%0d want 0 0", out_valid, inv); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(12'd23, rv, re, lat);
      checks++;
      if (rv !== 12'd1420 || re !== 1'b0 || lat !== 18)
         begin errors++; $display("FAIL reset_mid_after got inv=%0d err=%0b lat=%0d want 1420 0 18", rv, re, lat); end
   endtask

   task automatic test_back_to_back();
      int acc_c [2] = '{-1, -1};
      int hs_c [2]  = '{-1, -1};
      logic [11:0] res [2] = '{12'd0, 12'd0};
      int na = 0;
      int nh = 0;
      a = 12'd2;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 80 && nh < 2; c++) begin
         if (in_ready && in_valid && na < 2) begin acc_c[na] = c; na++; end
         if (out_valid && out_ready) begin res[nh] = inv; hs_c[nh] = c; nh++; end
         @(posedge clk); #1;
         if (na == 1) a = 12'd3;
         if (na == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (res[0] !== 12'd1485) begin errors++; $display("FAIL b2b_first got=%0d want=1485", res[0]); end
      checks++;
      if (res[1] !== 12'd990) begin errors++; $display("FAIL b2b_second got=%0d want=990", res[1]); end
      checks++;
      if (hs_c[0] - acc_c[0] != 19)
         begin errors++; $display("FAIL b2b_first_span got=%0d want=19", hs_c[0] - acc_c[0]); end
      checks++;
      if (acc_c[1] - hs_c[0] != 1)
         begin errors++; $display("FAIL b2b_reissue got=%0d want=1", acc_c[1] - hs_c[0]); end
   endtask

   initial begin
      test_reset();
      test_one();
      test_known();
      test_invalid();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
